// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry registered pipeline slice with valid/ready on both sides.
// Every output comes from a register, so no input reaches an output combinationally.
module pipe_skid_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t           state, next_state;
    logic [WIDTH-1:0] main, skid;
    logic             acc, take;
    assign acc  = in_valid && in_ready;
    assign take = out_valid && out_ready;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            main     <= '0;
            skid     <= '0;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= next_state != FULL;
            // main takes the new word when it would otherwise go empty; refills from skid when draining FULL
            if ((state == EMPTY && acc) || (state == ONE && acc && take))
                main <= in_data;
            else if (state == FULL && take)
                main <= skid;
            if (state == ONE && acc && !take)
                skid <= in_data;
        end
    end
    always_comb begin
        next_state = state == EMPTY ? (acc ? ONE : EMPTY)
                   : state == ONE   ? (acc && !take ? FULL : (!acc && take ? EMPTY : ONE))
                   :                  (take ? ONE : FULL);
    end
    always_comb begin
        out_valid = state != EMPTY;
        count     = state;
        out_data  = main;
    end
endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Two-entry registered pipeline slice with valid/ready handshakes on both sides. It is the consumer-facing counterpart of the team's plain capture registers. It accepts words from an upstream writer and presents them to a downstream reader, with full throughput and all outputs registered. It is placed between datapath stages wherever backpressure must be absorbed without a combinational ready path.

## Interface
- WIDTH, 16, data word width in bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  input  WIDTH  word from upstream.
- in_valid  input  1  upstream offers in_data this cycle.
- in_ready  output  1  slice can accept; registered.
- out_data  output  WIDTH  word presented downstream; registered.
- out_valid  output  1  out_data is valid; registered.
- out_ready  input  1  downstream takes out_data this cycle.
- count  output  2  words held: 0, 1 or 2; registered.

## Operation
- Handshake rules:
  - An input transfer ("acc") occurs on a rising edge with in_valid=1 and in_ready=1.
  - An output transfer ("take") occurs on a rising edge with out_valid=1 and out_ready=1.
- Storage is two registers:
  - main drives out_data.
  - skid holds the second word.
- State is EMPTY (count 0), ONE (count 1) or FULL (count 2).
- EMPTY:
  - acc -> ONE, main <= in_data.
  - Otherwise stay.
  - out_ready is ignored.
- ONE:
  - acc and take -> ONE, main <= in_data.
  - acc only -> FULL, skid <= in_data.
  - take only -> EMPTY.
  - Neither -> hold.
- FULL:
  - in_ready=0, so in_valid is ignored.
  - take -> ONE, main <= skid.
  - Otherwise hold.
- Decoded outputs:
  - out_valid = (state != EMPTY).
  - count encodes the state.
- in_ready register:
  - Loads (next_state != FULL) each edge.
  - It therefore deasserts the cycle after the slice becomes full.
  - It reasserts the cycle after a take from FULL.
- Ordering: words leave in arrival order. No word is dropped or duplicated.
- Stability:
  - While out_valid=1 and out_ready=0, out_data and out_valid stay constant.
  - in_data/in_valid changes while in_ready=0 have no effect.
- Reset (reset=0), asynchronous and immediate:
  - state EMPTY.
  - main, skid and out_data = 0.
  - out_valid=0, count=0, in_ready=0.
- After release: in_ready rises to 1 on the first rising edge where reset=1. No acc is possible before that edge.
- Reset mid-operation discards both held words. No transfer completes on the edge coincident with reset assertion.
- No arithmetic; all data paths are WIDTH bits wide, with no truncation.

## Timing
- Latency: a word accepted at edge N is on out_data with out_valid=1 after edge N (visible in cycle N+1), when the slice was EMPTY.
- Throughput: one word per cycle sustained when out_ready is held at 1. In that case count stays at 1 and in_ready stays at 1.
- No combinational path from any input to any output. in_ready does not depend on out_ready in the same cycle.
- Backpressure: with out_ready=0, at most two words are absorbed. in_ready=0 from the cycle following the second acc.
- Recovery: the first take from FULL moves skid to main at that edge. in_ready=1 in the next cycle.

## Test plan
- Reset release:
  - Drive reset=0 with in_valid=1, then release.
  - Required: out_valid=0, count=0 and in_ready=0 during reset; in_ready=1 after the first edge with reset=1; no word captured before it.
- Streaming:
  - Send 0x0001..0x0010 on consecutive cycles with out_ready=1.
  - Required: out_data 0x0001..0x0010 in order, 1-cycle latency, count constant at 1, in_ready never 0.
- Fill and stall:
  - out_ready=0; offer 0xAAAA, 0xBBBB, 0xCCCC.
  - Required: count 2; in_ready=0; 0xCCCC is not accepted; out_data holds 0xAAAA.
  - Then out_ready=1: required output 0xAAAA, 0xBBBB, then 0xCCCC once it is re-offered.
- Simultaneous acc and take in ONE:
  - Hold 0x1234, then on one edge take while accepting 0x5678.
  - Required: out_data=0x5678 next cycle, count stays 1.
- Random backpressure:
  - 1000 words with random in_valid and out_ready.
  - Required: scoreboard shows exact order, no loss or duplication; out_data stable whenever out_valid=1 and out_ready=0.
- Reset mid-operation:
  - Assert reset=0 asynchronously while FULL (0x1111, 0x2222).
  - Required: immediate out_valid=0, count=0, out_data=0; neither word appears after release.
